// File: rtl/level_flag_pkg.sv
// Shared constants for the level/flag display: glyph selector, segment order and
// active-low seven-segment patterns (bit 6 = a ... bit 0 = g, 0 = lit).
package level_flag_pkg;

  typedef enum logic [2:0] {
    GLY_BLANK = 3'd0,
    GLY_E     = 3'd1,
    GLY_F     = 3'd2,
    GLY_HEX   = 3'd3,
    GLY_BAR   = 3'd4
  } glyph_e;

  localparam int SEG_A_BIT = 6;
  localparam int SEG_B_BIT = 5;
  localparam int SEG_C_BIT = 4;
  localparam int SEG_D_BIT = 3;
  localparam int SEG_E_BIT = 2;
  localparam int SEG_F_BIT = 1;
  localparam int SEG_G_BIT = 0;

  localparam logic [6:0] SEG_E     = 7'h30; // a d e f g
  localparam logic [6:0] SEG_F     = 7'h38; // a e f g
  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_BAR   = 7'h4F; // b c

  localparam logic [6:0] HEX_SEG [16] = '{
    7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
    7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38
  };

  function automatic logic [6:0] hex_glyph(input logic [3:0] digit);
    return HEX_SEG[digit];
  endfunction

endpackage

// File: rtl/level_flag_display_if.sv
// Glyph request bundle between the display controller and the segment encoder.
interface level_flag_display_if
  import level_flag_pkg::*;
();

  glyph_e     sel;
  logic [3:0] digit;
  logic [6:0] seg;

  modport master (output sel, output digit, input seg);
  modport slave  (input sel, input digit, output seg);

endinterface

// File: rtl/level_flag_display_seg7_enc.sv
// Purely combinational glyph-to-segment encoder (active-low outputs).
module seg7_enc
  import level_flag_pkg::*;
(
  level_flag_display_if.slave enc
);

  always_comb begin
    enc.seg = SEG_BLANK;
    unique case (enc.sel)
      GLY_E:     enc.seg = SEG_E;
      GLY_F:     enc.seg = SEG_F;
      GLY_HEX:   enc.seg = hex_glyph(enc.digit);
      GLY_BAR:   enc.seg = SEG_BAR;
      GLY_BLANK: enc.seg = SEG_BLANK;
      default:   enc.seg = SEG_BLANK;
    endcase
  end

endmodule

// File: rtl/level_flag_display.sv
// Saturating occupancy counter with full/empty flags, sticky ovf/unf errors and a
// registered seven-segment display that blinks F while full.
module level_flag_display
  import level_flag_pkg::*;
#(
  parameter int LEVEL_W    = 3,
  parameter int BLINK_CYC  = 8,
  parameter int SHOW_LEVEL = 1
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               inc,
  input  logic               dec,
  output logic [LEVEL_W-1:0] level,
  output logic               full,
  output logic               empty,
  output logic               ovf,
  output logic               unf,
  output logic               led_a,
  output logic               led_b,
  output logic               led_c,
  output logic               led_d,
  output logic               led_e,
  output logic               led_f,
  output logic               led_g
);

  localparam logic [LEVEL_W-1:0] MAX = '1;
  localparam int CNT_W = (BLINK_CYC > 1) ? $clog2(BLINK_CYC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_CYC - 1);

  logic [LEVEL_W-1:0] level_q, level_d;
  logic               full_q, full_d;
  logic               empty_q, empty_d;
  logic               ovf_q, ovf_d;
  logic               unf_q, unf_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               phase_q, phase_d;
  logic [6:0]         led_q;

  level_flag_display_if enc_if ();

  seg7_enc u_seg7_enc (
    .enc (enc_if)
  );

  // Simultaneous inc/dec is a no-op, so it can never trip ovf/unf at the rails.
  always_comb begin
    level_d = level_q;
    ovf_d   = ovf_q;
    unf_d   = unf_q;
    if (inc && !dec) begin
      if (level_q == MAX) ovf_d = 1'b1;
      else                level_d = level_q + 1'b1;
    end else if (dec && !inc) begin
      if (level_q == '0) unf_d = 1'b1;
      else               level_d = level_q - 1'b1;
    end
    full_d  = (level_d == MAX);
    empty_d = (level_d == '0);
  end

  // Restarting on entry to full guarantees the blink always opens with a lit F.
  always_comb begin
    cnt_d   = cnt_q;
    phase_d = phase_q;
    if (full_d && !full_q) begin
      cnt_d   = '0;
      phase_d = 1'b1;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d   = '0;
      phase_d = ~phase_q;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_comb begin
    enc_if.sel   = GLY_BLANK;
    enc_if.digit = 4'(level_q);
    if (empty_q) begin
      enc_if.sel = GLY_E;
    end else if (full_q) begin
      enc_if.sel = phase_q ? GLY_F : GLY_BLANK;
    end else if (SHOW_LEVEL != 0) begin
      enc_if.sel = GLY_HEX;
    end else begin
      enc_if.sel = GLY_BAR;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      level_q <= '0;
      full_q  <= 1'b0;
      empty_q <= 1'b1;
      ovf_q   <= 1'b0;
      unf_q   <= 1'b0;
      cnt_q   <= '0;
      phase_q <= 1'b1;
      led_q   <= SEG_BLANK;
    end else begin
      level_q <= level_d;
      full_q  <= full_d;
      empty_q <= empty_d;
      ovf_q   <= ovf_d;
      unf_q   <= unf_d;
      cnt_q   <= cnt_d;
      phase_q <= phase_d;
      led_q   <= enc_if.seg;
    end
  end

  assign level = level_q;
  assign full  = full_q;
  assign empty = empty_q;
  assign ovf   = ovf_q;
  assign unf   = unf_q;
  assign {led_a, led_b, led_c, led_d, led_e, led_f, led_g} = led_q;

endmodule

// File: tb/tb_level_flag_display.sv
// Directed bench for level_flag_display: vector table for counting/flags/display,
// a hand-written blink sequence, and a standalone check of the segment encoder.
module tb_level_flag_display;
  import level_flag_pkg::*;

  // ---------------- clock / reset ----------------
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       inc = 1'b0;
  logic       dec = 1'b0;
  logic [2:0] level;
  logic       full, empty, ovf, unf;
  logic       led_a, led_b, led_c, led_d, led_e, led_f, led_g;
  logic [6:0] seg;

  always #5 clk = ~clk;

  assign seg = {led_a, led_b, led_c, led_d, led_e, led_f, led_g};

  level_flag_display #(
    .LEVEL_W    (3),
    .BLINK_CYC  (8),
    .SHOW_LEVEL (1)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .inc   (inc),
    .dec   (dec),
    .level (level),
    .full  (full),
    .empty (empty),
    .ovf   (ovf),
    .unf   (unf),
    .led_a (led_a),
    .led_b (led_b),
    .led_c (led_c),
    .led_d (led_d),
    .led_e (led_e),
    .led_f (led_f),
    .led_g (led_g)
  );

  level_flag_display_if enc_chk_if ();
  seg7_enc u_enc_chk (.enc(enc_chk_if));

  // ---------------- expected glyphs (active-low abcdefg) ----------------
  localparam logic [6:0] X_DARK = 7'h7F;
  localparam logic [6:0] X_E    = 7'h30;
  localparam logic [6:0] X_F    = 7'h38;
  localparam logic [6:0] X_BAR  = 7'h4F;
  logic [6:0] x_hex [16];

  typedef struct {
    logic       rst;
    logic       inc;
    logic       dec;
    logic [2:0] lvl;
    logic       full;
    logic       empty;
    logic       ovf;
    logic       unf;
    logic [6:0] seg;
  } vec_t;

  vec_t       vq[$];
  logic [6:0] exp_q[$];
  int         total = 0;
  int         bad   = 0;

  // ---------------- scoreboard ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver ----------------
  task automatic step(input logic r, input logic i, input logic d);
    rst = r;
    inc = i;
    dec = d;
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic r, input logic i, input logic d, input logic [2:0] l,
                     input logic f, input logic e, input logic o, input logic u,
                     input logic [6:0] s);
    vec_t v;
    v = '{rst: r, inc: i, dec: d, lvl: l, full: f, empty: e, ovf: o, unf: u, seg: s};
    vq.push_back(v);
  endtask

  task automatic run_vec(input int idx);
    vec_t v;
    v = vq[idx];
    step(v.rst, v.inc, v.dec);
    check($sformatf("v%0d_level", idx), 32'(level), 32'(v.lvl));
    check($sformatf("v%0d_full", idx),  32'(full),  32'(v.full));
    check($sformatf("v%0d_empty", idx), 32'(empty), 32'(v.empty));
    check($sformatf("v%0d_ovf", idx),   32'(ovf),   32'(v.ovf));
    check($sformatf("v%0d_unf", idx),   32'(unf),   32'(v.unf));
    check($sformatf("v%0d_seg", idx),   32'(seg),   32'(v.seg));
  endtask

  initial begin
    x_hex = '{7'h01, 7'h4F, 7'h12, 7'h06, 7'h4C, 7'h24, 7'h20, 7'h0F,
              7'h00, 7'h04, 7'h08, 7'h60, 7'h31, 7'h42, 7'h30, 7'h38};

    // reset + fill + overflow (rows 0..11)
    add(1,0,0, 0, 0,1,0,0, X_DARK);
    add(1,0,0, 0, 0,1,0,0, X_DARK);
    add(0,1,0, 1, 0,0,0,0, X_E);
    add(0,1,0, 2, 0,0,0,0, x_hex[1]);
    add(0,1,0, 3, 0,0,0,0, x_hex[2]);
    add(0,1,0, 4, 0,0,0,0, x_hex[3]);
    add(0,1,0, 5, 0,0,0,0, x_hex[4]);
    add(0,1,0, 6, 0,0,0,0, x_hex[5]);
    add(0,1,0, 7, 1,0,0,0, x_hex[6]);
    add(0,1,0, 7, 1,0,1,0, X_F);
    add(0,1,0, 7, 1,0,1,0, X_F);
    add(0,1,0, 7, 1,0,1,0, X_F);
    // reset, simultaneous inputs at 0/3/7 (rows 12..27)
    add(1,0,0, 0, 0,1,0,0, X_DARK);
    add(0,1,1, 0, 0,1,0,0, X_E);
    add(0,1,0, 1, 0,0,0,0, X_E);
    add(0,1,0, 2, 0,0,0,0, x_hex[1]);
    add(0,1,0, 3, 0,0,0,0, x_hex[2]);
    add(0,1,1, 3, 0,0,0,0, x_hex[3]);
    add(0,1,0, 4, 0,0,0,0, x_hex[3]);
    add(0,1,0, 5, 0,0,0,0, x_hex[4]);
    add(0,1,0, 6, 0,0,0,0, x_hex[5]);
    add(0,1,0, 7, 1,0,0,0, x_hex[6]);
    add(0,1,1, 7, 1,0,0,0, X_F);
    add(0,0,1, 6, 0,0,0,0, X_F);
    add(0,0,1, 5, 0,0,0,0, x_hex[6]);
    add(0,0,1, 4, 0,0,0,0, x_hex[5]);
    add(0,0,1, 3, 0,0,0,0, x_hex[4]);
    add(0,0,1, 2, 0,0,0,0, x_hex[3]);
    // underflow from 2 (rows 28..31)
    add(0,0,1, 1, 0,0,0,0, x_hex[2]);
    add(0,0,1, 0, 0,1,0,0, x_hex[1]);
    add(0,0,1, 0, 0,1,0,1, X_E);
    add(0,0,1, 0, 0,1,0,1, X_E);
    // climb to 5, then reset wins over inc (rows 32..38)
    add(0,1,0, 1, 0,0,0,1, X_E);
    add(0,1,0, 2, 0,0,0,1, x_hex[1]);
    add(0,1,0, 3, 0,0,0,1, x_hex[2]);
    add(0,1,0, 4, 0,0,0,1, x_hex[3]);
    add(0,1,0, 5, 0,0,0,1, x_hex[4]);
    add(1,1,0, 0, 0,1,0,0, X_DARK);
    add(0,0,0, 0, 0,1,0,0, X_E);

    // encoder standalone: every hex digit plus the special glyphs
    for (int d = 0; d < 16; d++) begin
      enc_chk_if.sel   = GLY_HEX;
      enc_chk_if.digit = 4'(d);
      #1;
      check($sformatf("enc_hex_%0h", d), 32'(enc_chk_if.seg), 32'(x_hex[d]));
    end
    enc_chk_if.sel = GLY_BAR;   #1; check("enc_bar",   32'(enc_chk_if.seg), 32'(X_BAR));
    enc_chk_if.sel = GLY_E;     #1; check("enc_e",     32'(enc_chk_if.seg), 32'(X_E));
    enc_chk_if.sel = GLY_F;     #1; check("enc_f",     32'(enc_chk_if.seg), 32'(X_F));
    enc_chk_if.sel = GLY_BLANK; #1; check("enc_blank", 32'(enc_chk_if.seg), 32'(X_DARK));

    for (int i = 0; i < 12; i++) run_vec(i);

    // blink: leave full, re-enter, then F x8 / blank x8 / F x8 while holding
    step(0, 0, 1);
    check("blink_leave_level", 32'(level), 32'd6);
    check("blink_leave_full",  32'(full),  32'd0);
    step(0, 1, 0);
    check("blink_enter_level", 32'(level), 32'd7);
    check("blink_enter_full",  32'(full),  32'd1);
    check("blink_enter_seg",   32'(seg),   32'(x_hex[6]));
    for (int k = 0; k < 24; k++) exp_q.push_back(((k / 8) % 2 == 0) ? X_F : X_DARK);
    for (int k = 0; k < 24; k++) begin
      logic [6:0] e;
      step(0, 0, 0);
      e = exp_q.pop_front();
      check($sformatf("blink_seg_%0d", k), 32'(seg), 32'(e));
    end
    check("blink_hold_level", 32'(level), 32'd7);
    check("blink_ovf_sticky", 32'(ovf),   32'd1);

    for (int i = 12; i < vq.size(); i++) run_vec(i);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
